// File: rtl/bcd_frame_parser.sv
// bcd_frame_parser: locks onto 100-word frames (3 markers, 93 data words,
// 3 zero words, 1 control word) and extracts data and control payloads.
// The optional PARSER_PARITY_CHECK_EN macro enables odd-parity checking of
// data and control words; without it only format errors and marker misses
// are flagged and counted.
module bcd_frame_parser (
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] iWord,
  input  logic        iValid,
  output logic [15:0] dout,
  output logic        dout_valid,
  output logic        dout_perr,
  output logic [15:0] wCtrl,
  output logic        ctrl_valid,
  output logic        locked,
  output logic        frame_done,
  output logic [7:0]  err_cnt
);

  localparam logic [17:0] MARKER = 18'h0FFFF;

  typedef enum logic [2:0] {
    HUNT,
    SYNC,
    DATA,
    TAIL,
    CTRL
  } state_t;

  state_t     state;
  logic [6:0] idx;
  logic [1:0] marker_cnt;
  logic       miss_flag;
  logic       miss_hist;

  logic is_marker;
  logic par_err;
  logic data_err;
  logic ctrl_ok;
  logic frame_miss;
  logic word_err;
  logic err_hit;

  // Per-word error classification for the word currently on iWord
  always_comb begin
    is_marker = (iWord == MARKER);
`ifdef PARSER_PARITY_CHECK_EN
    par_err   = ~(^iWord);
`else
    par_err   = 1'b0;
`endif
    data_err   = ~iWord[16] | par_err;
    ctrl_ok    = ~iWord[16] & ~par_err;
    frame_miss = miss_flag | ~is_marker;
    word_err   = 1'b0;
    case (state)
      SYNC:    word_err = ~is_marker;
      DATA:    word_err = data_err;
      TAIL:    word_err = |iWord;
      CTRL:    word_err = ~ctrl_ok;
      default: word_err = 1'b0;
    endcase
    err_hit = iValid & word_err;
  end

  // Frame state machine with registered outputs and saturating error counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      idx        <= 7'd0;
      marker_cnt <= 2'd0;
      miss_flag  <= 1'b0;
      miss_hist  <= 1'b0;
      dout       <= 16'd0;
      dout_valid <= 1'b0;
      dout_perr  <= 1'b0;
      wCtrl      <= 16'd0;
      ctrl_valid <= 1'b0;
      locked     <= 1'b0;
      frame_done <= 1'b0;
      err_cnt    <= 8'd0;
    end else begin
      dout_valid <= 1'b0;
      ctrl_valid <= 1'b0;
      frame_done <= 1'b0;
      if (err_hit && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
      if (iValid) begin
        case (state)
          HUNT: begin
            if (is_marker) begin
              if (marker_cnt == 2'd2) begin
                state      <= DATA;
                idx        <= 7'd3;
                locked     <= 1'b1;
                marker_cnt <= 2'd0;
                miss_flag  <= 1'b0;
                miss_hist  <= 1'b0;
              end else begin
                marker_cnt <= marker_cnt + 2'd1;
              end
            end else begin
              marker_cnt <= 2'd0;
            end
          end
          SYNC: begin
            if (idx == 7'd2) begin
              miss_flag <= 1'b0;
              if (frame_miss && miss_hist) begin
                state      <= HUNT;
                idx        <= 7'd0;
                locked     <= 1'b0;
                miss_hist  <= 1'b0;
                marker_cnt <= 2'd0;
              end else begin
                miss_hist <= frame_miss;
                state     <= DATA;
                idx       <= 7'd3;
              end
            end else begin
              if (!is_marker) begin
                miss_flag <= 1'b1;
              end
              idx <= idx + 7'd1;
            end
          end
          DATA: begin
            dout       <= iWord[15:0];
            dout_valid <= 1'b1;
            dout_perr  <= data_err;
            if (idx == 7'd95) begin
              state <= TAIL;
            end
            idx <= idx + 7'd1;
          end
          TAIL: begin
            if (idx == 7'd98) begin
              state <= CTRL;
            end
            idx <= idx + 7'd1;
          end
          CTRL: begin
            if (ctrl_ok) begin
              wCtrl      <= iWord[15:0];
              ctrl_valid <= 1'b1;
            end
            frame_done <= 1'b1;
            idx        <= 7'd0;
            state      <= SYNC;
          end
          default: begin
            state <= HUNT;
            idx   <= 7'd0;
          end
        endcase
      end
    end
  end

endmodule
